// File: rtl/lcd_readback.sv
// Reads one 16-character DDRAM line, plus busy flag and address counter, back from an
// HD44780-compatible LCD using timed SETUP / EN_HI / HOLD bus accesses.
module lcd_readback #(
    parameter int SETUP_CYCLES = 8,
    parameter int EN_CYCLES    = 24,
    parameter int HOLD_CYCLES  = 16,
    parameter int BF_TIMEOUT   = 1024
) (
    input  logic             iCLK_50,
    input  logic             iRST,
    input  logic             iStart,
    input  logic             iLine,
    output logic             oLCD_EN,
    output logic             oLCD_RS,
    output logic             oLCD_RW,
    output logic [7:0]       oLCD_D,
    output logic             oLCD_D_OE,
    input  logic [7:0]       iLCD_D,
    output logic [0:15][7:0] oString,
    output logic [6:0]       oAddr,
    output logic             oValid,
    output logic             oBusy,
    output logic             oError
);

    localparam int CW = 16;
    localparam int PW = $clog2(BF_TIMEOUT) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POLL  = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_RDATA = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] P_SETUP = 2'd0;
    localparam logic [1:0] P_EN    = 2'd1;
    localparam logic [1:0] P_HOLD  = 2'd2;

    logic [2:0]       seq_q, seq_d;
    logic [1:0]       phase_q, phase_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic             cmd_done_q, cmd_done_d;
    logic [PW-1:0]    poll_cnt_q, poll_cnt_d;
    logic             line_q, line_d;
    logic [7:0]       rd_q, rd_d;
    logic [0:15][7:0] line_buf_q, line_buf_d;
    logic [0:15][7:0] str_q, str_d;
    logic [6:0]       addr_q, addr_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             error_q, error_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic             rw_q, rw_d;
    logic [7:0]       d_q, d_d;
    logic             oe_q, oe_d;

    logic             access_end;
    logic             rdata_end;
    logic             access_d;
    logic [15:0]      slot_we;

    assign access_end = (phase_q == P_HOLD) && (cnt_q == CW'(HOLD_CYCLES - 1));
    assign rdata_end  = access_end && (seq_q == S_RDATA);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            assign slot_we[gi] = rdata_end && (idx_q == 4'(gi));
        end
    endgenerate

    always_comb begin
        seq_d      = seq_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        last_d     = last_q;
        cmd_done_d = cmd_done_q;
        poll_cnt_d = poll_cnt_q;
        line_d     = line_q;
        rd_d       = rd_q;
        str_d      = str_q;
        addr_d     = addr_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        error_d    = error_q;

        line_buf_d = line_buf_q;
        for (int i = 0; i < 16; i++) begin
            if (slot_we[i]) line_buf_d[i] = rd_q;
        end

        case (seq_q)
            S_IDLE: begin
                if (iStart) begin
                    seq_d      = S_POLL;
                    phase_d    = P_SETUP;
                    cnt_d      = '0;
                    idx_d      = '0;
                    last_d     = 1'b0;
                    cmd_done_d = 1'b0;
                    poll_cnt_d = '0;
                    line_d     = iLine;
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                end
            end
            S_POLL, S_CMD, S_RDATA: begin
                cnt_d = cnt_q + CW'(1);
                case (phase_q)
                    P_SETUP: begin
                        if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                            phase_d = P_EN;
                            cnt_d   = '0;
                        end
                    end
                    P_EN: begin
                        // Read data is taken on the same edge that drops EN.
                        if (cnt_q == CW'(EN_CYCLES - 1)) begin
                            phase_d = P_HOLD;
                            cnt_d   = '0;
                            rd_d    = iLCD_D;
                        end
                    end
                    default: begin
                        if (access_end) begin
                            phase_d = P_SETUP;
                            cnt_d   = '0;
                            if (seq_q == S_POLL) begin
                                if (rd_q[7]) begin
                                    if (poll_cnt_q == PW'(BF_TIMEOUT - 1)) begin
                                        seq_d   = S_IDLE;
                                        busy_d  = 1'b0;
                                        error_d = 1'b1;
                                    end else begin
                                        poll_cnt_d = poll_cnt_q + PW'(1);
                                    end
                                end else begin
                                    poll_cnt_d = '0;
                                    if (!cmd_done_q) begin
                                        seq_d = S_CMD;
                                    end else if (last_q) begin
                                        // Publish the whole line and AC at once.
                                        seq_d   = S_DONE;
                                        str_d   = line_buf_q;
                                        addr_d  = rd_q[6:0];
                                        valid_d = 1'b1;
                                    end else begin
                                        seq_d = S_RDATA;
                                    end
                                end
                            end else if (seq_q == S_CMD) begin
                                cmd_done_d = 1'b1;
                                seq_d      = S_POLL;
                            end else begin
                                idx_d = idx_q + 4'd1;
                                if (idx_q == 4'd15) last_d = 1'b1;
                                seq_d = S_POLL;
                            end
                        end
                    end
                endcase
            end
            S_DONE: begin
                seq_d  = S_IDLE;
                busy_d = 1'b0;
            end
            default: begin
                seq_d = S_IDLE;
            end
        endcase

        // Bus controls follow the next state, so they only move as a new SETUP begins.
        access_d = (seq_d == S_POLL) || (seq_d == S_CMD) || (seq_d == S_RDATA);
        en_d     = access_d && (phase_d == P_EN);
        rs_d     = (seq_d == S_RDATA);
        rw_d     = (seq_d == S_POLL) || (seq_d == S_RDATA);
        oe_d     = (seq_d == S_CMD);
        d_d      = oe_d ? {1'b1, line_d, 6'b0} : 8'h00;
    end

    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            seq_q      <= S_IDLE;
            phase_q    <= P_SETUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            cmd_done_q <= 1'b0;
            poll_cnt_q <= '0;
            line_q     <= 1'b0;
            rd_q       <= '0;
            line_buf_q <= '0;
            str_q      <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            d_q        <= '0;
            oe_q       <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            cmd_done_q <= cmd_done_d;
            poll_cnt_q <= poll_cnt_d;
            line_q     <= line_d;
            rd_q       <= rd_d;
            line_buf_q <= line_buf_d;
            str_q      <= str_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
            en_q       <= en_d;
            rs_q       <= rs_d;
            rw_q       <= rw_d;
            d_q        <= d_d;
            oe_q       <= oe_d;
        end
    end

    assign oLCD_EN   = en_q;
    assign oLCD_RS   = rs_q;
    assign oLCD_RW   = rw_q;
    assign oLCD_D    = d_q;
    assign oLCD_D_OE = oe_q;
    assign oString   = str_q;
    assign oAddr     = addr_q;
    assign oValid    = valid_q;
    assign oBusy     = busy_q;
    assign oError    = error_q;

endmodule

// File: tb/tb_lcd_readback.sv
// Directed bench for lcd_readback: an HD44780 DDRAM/BF model, a table of line reads,
// plus reset, timeout and ignored-start sequences and a continuous bus timing monitor.
module tb_lcd_readback;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             line = 1'b0;
    logic             lcd_en, lcd_rs, lcd_rw, lcd_oe;
    logic [7:0]       lcd_d, lcd_in;
    logic [0:15][7:0] dut_str;
    logic [6:0]       dut_addr;
    logic             dut_valid, dut_busy, dut_error;

    int n_cmp = 0;
    int n_mis = 0;

    always #10 clk = ~clk;

    lcd_readback dut (
        .iCLK_50   (clk),
        .iRST      (rst),
        .iStart    (start),
        .iLine     (line),
        .oLCD_EN   (lcd_en),
        .oLCD_RS   (lcd_rs),
        .oLCD_RW   (lcd_rw),
        .oLCD_D    (lcd_d),
        .oLCD_D_OE (lcd_oe),
        .iLCD_D    (lcd_in),
        .oString   (dut_str),
        .oAddr     (dut_addr),
        .oValid    (dut_valid),
        .oBusy     (dut_busy),
        .oError    (dut_error)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- LCD model ----------------
    logic [7:0] ddram [0:127];
    logic [6:0] ac_m = '0;
    logic       en_prev_m = 1'b0;
    logic       model_clr = 1'b0;
    int         cfg_bf = 0;
    bit         cfg_stuck = 1'b0;
    int         bf_left = 0;
    int         n_acc = 0, n_wr = 0, n_poll = 0;
    logic [7:0] wr_d = '0;
    logic       wr_rs = 1'b0, wr_oe = 1'b0;
    logic       bf_now;

    assign bf_now = cfg_stuck || (bf_left != 0);
    assign lcd_in = lcd_rs ? ddram[ac_m] : {bf_now, ac_m};

    always @(posedge clk) begin
        en_prev_m <= lcd_en;
        if (model_clr) begin
            bf_left <= cfg_bf;
            n_acc   <= 0;
            n_wr    <= 0;
            n_poll  <= 0;
            wr_d    <= '0;
            wr_rs   <= 1'b0;
            wr_oe   <= 1'b0;
        end else if (en_prev_m && !lcd_en && !rst) begin
            n_acc <= n_acc + 1;
            if (!lcd_rw) begin
                n_wr  <= n_wr + 1;
                wr_d  <= lcd_d;
                wr_rs <= lcd_rs;
                wr_oe <= lcd_oe;
                if (!lcd_rs && lcd_d[7]) ac_m <= lcd_d[6:0];
            end else if (!lcd_rs) begin
                n_poll <= n_poll + 1;
                if (bf_left > 0) bf_left <= bf_left - 1;
            end else begin
                ac_m <= ac_m + 7'd1;
            end
        end
    end

    // ---------------- bus timing monitor ----------------
    logic       mon_prev_en = 1'b0;
    logic [9:0] mon_prev_sig = '0;
    logic [9:0] mon_sig;
    int         en_run = 0, stab = 0, hold_cnt = 0;
    bit         hold_armed = 1'b0;

    always @(negedge clk) begin
        mon_sig = {lcd_rs, lcd_rw, lcd_d};
        if (rst) begin
            mon_prev_en  = 1'b0;
            en_run       = 0;
            stab         = 0;
            hold_armed   = 1'b0;
            mon_prev_sig = mon_sig;
        end else begin
            if (mon_sig != mon_prev_sig) begin
                if (hold_armed) chk("hold_time_ge16", 128'(hold_cnt >= 16), 128'd1);
                hold_armed = 1'b0;
                stab = 1;
            end else begin
                stab++;
            end
            if (lcd_en && !mon_prev_en) begin
                chk("setup_time_ge8", 128'((stab - 1) >= 8), 128'd1);
                chk("oe_is_not_rw", 128'(lcd_oe), 128'(!lcd_rw));
                if (hold_armed) chk("hold_time_ge16", 128'(hold_cnt >= 16), 128'd1);
                hold_armed = 1'b0;
            end
            if (lcd_en) en_run++;
            if (!lcd_en && mon_prev_en) begin
                chk("en_width", 128'(en_run), 128'd24);
                en_run     = 0;
                hold_armed = 1'b1;
                hold_cnt   = 1;
            end else if (!lcd_en && hold_armed) begin
                hold_cnt++;
            end
            if (lcd_oe && lcd_rw) chk("oe_with_rw", 128'd1, 128'd0);
            mon_prev_en  = lcd_en;
            mon_prev_sig = mon_sig;
        end
    end

    // ---------------- one full read transaction ----------------
    task automatic run_read(input logic ln, input int bf, input bit stuck, input bit extra,
                            output int lat, output int nval, output int fall, output bit tmo);
        int n;
        bit fin;
        cfg_bf    = bf;
        cfg_stuck = stuck;
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
        start = 1'b1;
        line  = ln;
        @(negedge clk);
        start = 1'b0;
        n = 1; fin = 1'b0; lat = 0; nval = 0; fall = 0; tmo = 1'b0;
        chk("busy_after_accept", 128'(dut_busy), 128'd1);
        chk("error_cleared_at_accept", 128'(dut_error), 128'd0);
        while (!fin) begin
            if (dut_valid) begin
                nval++;
                if (lat == 0) lat = n;
            end
            if (!dut_busy) begin
                fall = n;
                fin  = 1'b1;
            end else if (n >= 60000) begin
                tmo = 1'b1;
                fin = 1'b1;
            end else begin
                if (n == 2) line = ~ln;
                start = extra && (n == 100 || n == 900);
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        chk("finished_within_bound", 128'(tmo), 128'd0);
    endtask

    typedef struct {
        logic         ln;
        int           bf;
        logic [127:0] exp_str;
        logic [7:0]   exp_d;
        int           exp_lat;
        logic [6:0]   exp_addr;
    } vec_t;

    initial begin
        logic [127:0] s0, s1;
        logic [7:0]   ch0, exp_ch0;
        vec_t         vecs [4];
        int           lat, nval, fall;
        bit           tmo;
        bit           got_en;

        s0 = "HELLO WORLD     ";
        s1 = "0123456789ABCDEF";
        for (int i = 0; i < 128; i++) ddram[i] = 8'h20;
        for (int i = 0; i < 16; i++) begin
            ddram[i]      = s0[127 - 8*i -: 8];
            ddram[64 + i] = s1[127 - 8*i -: 8];
        end

        vecs[0] = '{1'b0, 0, s0, 8'h80, 1681, 7'h10};
        vecs[1] = '{1'b1, 3, s1, 8'hC0, 1825, 7'h50};
        vecs[2] = '{1'b1, 0, s1, 8'hC0, 1681, 7'h50};
        vecs[3] = '{1'b0, 1, s0, 8'h80, 1729, 7'h10};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_en", 128'(lcd_en), 128'd0);
        chk("reset_busy", 128'(dut_busy), 128'd0);
        chk("reset_valid", 128'(dut_valid), 128'd0);
        chk("reset_error", 128'(dut_error), 128'd0);
        chk("reset_string", dut_str, 128'd0);
        chk("reset_rw_oe", 128'({lcd_rw, lcd_oe, lcd_rs}), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            run_read(vecs[r].ln, vecs[r].bf, 1'b0, 1'b0, lat, nval, fall, tmo);
            $display("read %0d: line=%0d bf_polls=%0d latency=%0d valid_pulses=%0d accesses=%0d addr=0x%0h",
                     r, vecs[r].ln, vecs[r].bf, lat, nval, n_acc, dut_addr);
            ch0     = dut_str[0];
            exp_ch0 = vecs[r].exp_str[127:120];
            chk("valid_latency", 128'(lat), 128'(vecs[r].exp_lat));
            chk("valid_pulse_count", 128'(nval), 128'd1);
            chk("busy_fall_after_valid", 128'(fall), 128'(vecs[r].exp_lat + 1));
            chk("string", dut_str, vecs[r].exp_str);
            chk("string_first_char", 128'(ch0), 128'(exp_ch0));
            chk("addr", 128'(dut_addr), 128'(vecs[r].exp_addr));
            chk("write_count", 128'(n_wr), 128'd1);
            chk("cmd_byte", 128'(wr_d), 128'(vecs[r].exp_d));
            chk("cmd_rs_oe", 128'({wr_rs, wr_oe}), 128'b01);
            chk("access_count", 128'(n_acc), 128'(35 + vecs[r].bf));
            chk("poll_count", 128'(n_poll), 128'(18 + vecs[r].bf));
            chk("error_clear", 128'(dut_error), 128'd0);
        end

        // Busy flag stuck high: abort after the timeout, outputs untouched.
        run_read(1'b1, 0, 1'b1, 1'b0, lat, nval, fall, tmo);
        $display("timeout read: polls=%0d accesses=%0d valid_pulses=%0d error=%0d busy=%0d",
                 n_poll, n_acc, nval, dut_error, dut_busy);
        chk("timeout_poll_count", 128'(n_poll), 128'd1024);
        chk("timeout_access_count", 128'(n_acc), 128'd1024);
        chk("timeout_no_valid", 128'(nval), 128'd0);
        chk("timeout_error", 128'(dut_error), 128'd1);
        chk("timeout_busy", 128'(dut_busy), 128'd0);
        chk("timeout_string_kept", dut_str, vecs[3].exp_str);
        chk("timeout_addr_kept", 128'(dut_addr), 128'(vecs[3].exp_addr));

        // Next read clears the error and ignores extra start pulses.
        run_read(1'b0, 0, 1'b0, 1'b1, lat, nval, fall, tmo);
        $display("restart read: latency=%0d valid_pulses=%0d accesses=%0d error=%0d",
                 lat, nval, n_acc, dut_error);
        chk("restart_latency", 128'(lat), 128'd1681);
        chk("restart_valid_count", 128'(nval), 128'd1);
        chk("restart_access_count", 128'(n_acc), 128'd35);
        chk("restart_string", dut_str, s0);
        chk("restart_error", 128'(dut_error), 128'd0);

        // Reset in the middle of an EN-high window.
        start = 1'b1;
        line  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        got_en = 1'b0;
        for (int k = 0; k < 200 && !got_en; k++) begin
            if (lcd_en) got_en = 1'b1;
            else @(negedge clk);
        end
        chk("reset_test_reached_en", 128'(got_en), 128'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("mid-access reset: en=%0d busy=%0d valid=%0d error=%0d", lcd_en, dut_busy, dut_valid, dut_error);
        chk("midreset_en", 128'(lcd_en), 128'd0);
        chk("midreset_busy", 128'(dut_busy), 128'd0);
        chk("midreset_valid", 128'(dut_valid), 128'd0);
        chk("midreset_error", 128'(dut_error), 128'd0);
        chk("midreset_string", dut_str, 128'd0);
        chk("midreset_addr", 128'(dut_addr), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_read(1'b1, 0, 1'b0, 1'b0, lat, nval, fall, tmo);
        $display("post-reset read: latency=%0d valid_pulses=%0d addr=0x%0h", lat, nval, dut_addr);
        chk("postreset_latency", 128'(lat), 128'd1681);
        chk("postreset_valid_count", 128'(nval), 128'd1);
        chk("postreset_string", dut_str, s1);
        chk("postreset_addr", 128'(dut_addr), 128'h50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
